// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared state encoding and grant identifiers for l1 port arbitration
package l1_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the side not granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = &req ? ~last : req[1];
endmodule

// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter: shares the single l1_cache read port between fetch and data stages
module l1_port_arbiter
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              cache_en,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_data,
  input  logic              cache_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            state_q, state_d;
  logic              grant_q, grant_d, last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic              err_q, err_d, busy_q, busy_d, cache_en_q, cache_en_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic              gnt_valid, gnt_id, done;
  rr_arb2 u_rr (
    .req      ({d_req, if_req}),
    .last     (last_q),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );
  assign done = cache_ready || cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = err_q;
    busy_d       = busy_q;
    cache_en_d   = 1'b0;
    rdata_d      = rdata_q;
    cache_addr_d = cache_addr_q;
    case (state_q)
      ST_IDLE: if (gnt_valid) begin
        grant_d      = gnt_id;
        last_d       = gnt_id;
        cache_addr_d = gnt_id == GRANT_D ? d_addr : if_addr;
        cache_en_d   = 1'b1;
        busy_d       = 1'b1;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (done) begin
        // a timeout reports err with a zero word so stale data never leaks out
        rdata_d  = cache_ready ? cache_data : '0;
        err_d    = !cache_ready;
        if_ack_d = grant_q == GRANT_IF;
        d_ack_d  = grant_q == GRANT_D;
        state_d  = ST_RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_RESP: begin
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_IF;
      last_q       <= GRANT_D;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      cache_en_q   <= 1'b0;
      rdata_q      <= '0;
      cache_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      cache_en_q   <= cache_en_d;
      rdata_q      <= rdata_d;
      cache_addr_q <= cache_addr_d;
    end
  end
  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign cache_en   = cache_en_q;
  assign rdata      = rdata_q;
  assign cache_addr = cache_addr_q;
endmodule

// File: tb/tb_l1_port_arbiter.sv
// tb_l1_port_arbiter: directed vectors for l1_port_arbiter against hand-computed cycle timing
module tb_l1_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0;
  logic        if_ack, d_ack, err, busy, cache_en;
  logic [31:0] rdata, cache_data;
  logic [15:0] cache_addr;
  logic        cache_ready = 1'b1;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  logic [15:0] mem_addr = '0;
  int          checks = 0;
  int          errors = 0;

  l1_port_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .cache_en(cache_en), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_ready(cache_ready)
  );

  always #5 clk = ~clk;

  // cache model: latches the address when enabled, returns a word tagged with it
  always @(posedge clk) if (cache_en) mem_addr <= cache_addr;
  assign cache_data = use_fixed ? fixed_data : {16'hC0DE, mem_addr};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  always @(negedge clk) if (rst) chk("ack_excl", {63'd0, if_ack & d_ack}, 64'd0);

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // scenario 1: reset with toggling inputs, then a single fetch
    for (int i = 0; i < 3; i++) begin
      if_req = i[0]; d_req = ~i[0]; if_addr = 16'(i * 7);
      cyc();
      chk("rst_outs", {if_ack, d_ack, cache_en, busy, err}, 5'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_caddr", cache_addr, 16'h0);
    end
    if_req = 0; d_req = 0; rst = 1'b1;
    cyc();
    use_fixed = 1; fixed_data = 32'hDEADBEEF; cache_ready = 1;
    if_addr = 16'h0005; if_req = 1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("s1_if_ack", if_ack, c == 3);
      if (c == 1) begin
        chk("s1_cache_en", cache_en, 1);
        chk("s1_cache_addr", cache_addr, 16'h0005);
      end
      if (c == 2) chk("s1_cache_en_off", cache_en, 0);
      if (c == 3) begin
        chk("s1_rdata", rdata, 32'hDEADBEEF);
        chk("s1_err", err, 0);
        if_req = 0;
      end
      if (c == 4) chk("s1_busy_low", busy, 0);
    end
    use_fixed = 0;

    // scenario 2: simultaneous requests alternate
    do_reset();
    if_addr = 16'h0010; d_addr = 16'h0020; if_req = 1; d_req = 1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("s2_if_ack", if_ack, c == 3);
      chk("s2_d_ack", d_ack, c == 7);
      if (c == 1) chk("s2_addr_if", cache_addr, 16'h0010);
      if (c == 5) chk("s2_addr_d", cache_addr, 16'h0020);
      if (c == 3) begin chk("s2_rdata_if", rdata, 32'hC0DE0010); if_req = 0; end
      if (c == 7) begin chk("s2_rdata_d", rdata, 32'hC0DE0020); d_req = 0; end
    end
    if_req = 1; d_req = 1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("s2b_if_ack", if_ack, c == 3 || c == 11);
      chk("s2b_d_ack", d_ack, c == 7);
      if (c == 1) chk("s2b_addr_if", cache_addr, 16'h0010);
      if (c == 3) if_addr = 16'h0011;
      if (c == 5) chk("s2b_addr_d_tie", cache_addr, 16'h0020);
      if (c == 7) d_req = 0;
      if (c == 9) chk("s2b_addr_if2", cache_addr, 16'h0011);
      if (c == 11) begin chk("s2b_rdata", rdata, 32'hC0DE0011); if_req = 0; end
    end

    // scenario 3: timeout
    cache_ready = 0; if_addr = 16'h0040; if_req = 1;
    for (int c = 1; c <= 18; c++) begin
      cyc();
      chk("s3_if_ack", if_ack, c == 17);
      if (c == 17) begin
        chk("s3_err", err, 1);
        chk("s3_rdata", rdata, 32'h0);
        chk("s3_busy", busy, 1);
        if_req = 0;
      end
      if (c == 18) begin
        chk("s3_busy_low", busy, 0);
        chk("s3_err_low", err, 0);
      end
    end
    cache_ready = 1; if_addr = 16'h0041; if_req = 1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("s3n_if_ack", if_ack, c == 3);
      if (c == 3) begin
        chk("s3n_rdata", rdata, 32'hC0DE0041);
        chk("s3n_err", err, 0);
        if_req = 0;
      end
    end

    // scenario 4: three wait cycles
    use_fixed = 1; fixed_data = 32'h0; cache_ready = 0; if_addr = 16'h0050; if_req = 1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk("s4_if_ack", if_ack, c == 6);
      if (c == 5) begin cache_ready = 1; fixed_data = 32'h12345678; end
      if (c == 6) begin
        chk("s4_rdata", rdata, 32'h12345678);
        chk("s4_err", err, 0);
        if_req = 0;
      end
    end
    use_fixed = 0;

    // scenario 5: reset during WAIT drops the transaction
    cache_ready = 0; d_addr = 16'h0020; d_req = 1;
    repeat (4) cyc();
    chk("s5_busy_wait", busy, 1);
    rst = 0;
    cyc();
    chk("s5_rst_outs", {if_ack, d_ack, cache_en, busy, err}, 5'b0);
    chk("s5_rst_rdata", rdata, 32'h0);
    chk("s5_rst_caddr", cache_addr, 16'h0);
    cache_ready = 1; rst = 1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("s5_d_ack", d_ack, c == 3);
      if (c == 1) chk("s5_caddr", cache_addr, 16'h0020);
      if (c == 3) begin chk("s5_rdata", rdata, 32'hC0DE0020); d_req = 0; end
    end

    // scenario 6: address change after grant has no effect
    cache_ready = 0; d_addr = 16'h0020; d_req = 1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk("s6_d_ack", d_ack, c == 4);
      if (c == 2) d_addr = 16'h0030;
      if (c == 3) begin chk("s6_caddr", cache_addr, 16'h0020); cache_ready = 1; end
      if (c == 4) begin chk("s6_rdata", rdata, 32'hC0DE0020); d_req = 0; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
